// File: rtl/retro16_pkg.sv
// Shared types and sizes for the retro16 core.
// The writeback entry layout is used by the queue and the writeback stage.
package retro16_pkg;

    localparam int REG_W     = 3;
    localparam int DATA_W    = 16;
    localparam int NUM_BANKS = 2;
    localparam int NUM_REGS  = 1 << REG_W;

    typedef struct packed {
        logic              bank;
        logic [REG_W-1:0]  reg_num;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic wb_entry_t make_entry(
        input logic              bank,
        input logic [REG_W-1:0]  reg_num,
        input logic [DATA_W-1:0] data
    );
        wb_entry_t e;
        e.bank    = bank;
        e.reg_num = reg_num;
        e.data    = data;
        return e;
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Bus bundle for the writeback stage: two producer ports, flush, the
// register-file write port and the decode busy queries.
interface writeback_unit_if;
    import retro16_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_W-1:0]  alu_reg;
    logic              alu_bank;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [REG_W-1:0]  mem_reg;
    logic              mem_bank;
    logic [DATA_W-1:0] mem_data;

    logic              flush;

    logic              write_en;
    logic [REG_W-1:0]  write_register_num;
    logic [DATA_W-1:0] write_register_in;
    logic              write_bank;

    logic [REG_W-1:0]  left_register_num;
    logic [REG_W-1:0]  right_register_num;
    logic              query_bank;
    logic              left_busy;
    logic              right_busy;
    logic              empty;

    modport master (
        output alu_valid, alu_reg, alu_bank, alu_data,
        input  alu_ready,
        output mem_valid, mem_reg, mem_bank, mem_data,
        input  mem_ready,
        output flush,
        input  write_en, write_register_num, write_register_in, write_bank,
        output left_register_num, right_register_num, query_bank,
        input  left_busy, right_busy, empty
    );

    modport slave (
        input  alu_valid, alu_reg, alu_bank, alu_data,
        output alu_ready,
        input  mem_valid, mem_reg, mem_bank, mem_data,
        output mem_ready,
        input  flush,
        output write_en, write_register_num, write_register_in, write_bank,
        input  left_register_num, right_register_num, query_bank,
        output left_busy, right_busy, empty
    );

endinterface

// File: rtl/wb_fifo.sv
// Dual-push, single-pop result queue. Port A is always the older entry
// when both ports push in the same cycle.
module wb_fifo
    import retro16_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push_a,
    input  wb_entry_t        data_a,
    input  logic             push_b,
    input  wb_entry_t        data_b,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_b;
    logic [1:0]       push_cnt;

    assign push_cnt = {1'b0, push_a} + {1'b0, push_b};
    assign wr_ptr_b = push_a ? wr_ptr + 1'b1 : wr_ptr;
    assign head     = mem[rd_ptr];

    // Callers never push past DEPTH, so count stays in range without a guard.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push_cnt) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_a) begin
            mem[wr_ptr] <= data_a;
        end
        if (push_b) begin
            mem[wr_ptr_b] <= data_b;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: queues ALU and load results, issues one register-file
// write per cycle and tracks per-register outstanding writes for decode.
module writeback_unit
    import retro16_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input logic             clk,
    input logic             rst,
    writeback_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count;
    wb_entry_t        head;
    wb_entry_t        mem_entry;
    wb_entry_t        alu_entry;
    logic             mem_fire;
    logic             alu_fire;
    logic             pop;

    logic [NUM_BANKS*NUM_REGS-1:0] busy_vec;

    assign mem_entry = make_entry(bus.mem_bank, bus.mem_reg, bus.mem_data);
    assign alu_entry = make_entry(bus.alu_bank, bus.alu_reg, bus.alu_data);

    // The ALU port reserves a slot for a load offered in the same cycle,
    // whether or not the ALU itself is valid, so loads keep priority.
    always_comb begin
        bus.mem_ready = !bus.flush && (count < DEPTH_C);
        bus.alu_ready = !bus.flush &&
                        ((count + CNT_W'(bus.mem_valid)) < DEPTH_C);
        mem_fire      = bus.mem_valid && bus.mem_ready;
        alu_fire      = bus.alu_valid && bus.alu_ready;
        pop           = (count != '0) && !bus.flush;
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.flush),
        .push_a (mem_fire),
        .data_a (mem_entry),
        .push_b (alu_fire),
        .data_b (alu_entry),
        .pop    (pop),
        .head   (head),
        .count  (count)
    );

    // The write port holds its last address/data when idle; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.write_en           <= 1'b0;
            bus.write_register_num <= '0;
            bus.write_register_in  <= '0;
            bus.write_bank         <= 1'b0;
        end else begin
            bus.write_en <= pop;
            if (pop) begin
                bus.write_register_num <= head.reg_num;
                bus.write_register_in  <= head.data;
                bus.write_bank         <= head.bank;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign busy_vec[b*NUM_REGS] = 1'b0;

        for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
            logic [CNT_W-1:0] pending;
            logic             mem_hit;
            logic             alu_hit;
            logic             wr_hit;

            assign mem_hit = mem_fire && (bus.mem_bank == 1'(b)) &&
                             (bus.mem_reg == REG_W'(r));
            assign alu_hit = alu_fire && (bus.alu_bank == 1'(b)) &&
                             (bus.alu_reg == REG_W'(r));
            assign wr_hit  = bus.write_en && (bus.write_bank == 1'(b)) &&
                             (bus.write_register_num == REG_W'(r));

            // Retire at the end of the write cycle so busy drops exactly when
            // the register file holds the value.
            always_ff @(posedge clk) begin
                if (rst || bus.flush) begin
                    pending <= '0;
                end else begin
                    pending <= pending + CNT_W'(mem_hit) + CNT_W'(alu_hit)
                               - CNT_W'(wr_hit);
                end
            end

            assign busy_vec[b*NUM_REGS+r] = (pending != '0);
        end
    end

    always_comb begin
        bus.left_busy  = (bus.left_register_num != '0) &&
                         busy_vec[{bus.query_bank, bus.left_register_num}];
        bus.right_busy = (bus.right_register_num != '0) &&
                         busy_vec[{bus.query_bank, bus.right_register_num}];
        bus.empty      = (count == '0) && !bus.write_en;
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vector table, a fill and
// a flush sequence, then randomized traffic against a queue-based model.
module tb_writeback_unit;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic        bank;
        logic [2:0]  rnum;
        logic [15:0] data;
    } ent_t;

    typedef struct {
        logic       rst;
        logic       flush;
        logic       mv;
        ent_t       me;
        logic       av;
        ent_t       ae;
        logic [2:0] lq;
        logic [2:0] rq;
        logic       qb;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        we;
        logic [2:0]  wnum;
        logic [15:0] wdata;
        logic        wbank;
        logic        lb;
        logic        rb;
        logic        mrdy;
        logic        ardy;
        logic        emp;
    } vec_t;

    logic clk;
    logic rst;

    writeback_unit_if bus();

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks;
    int    failures;
    int    throttled;
    stim_t cur;
    ent_t  mq[$];
    logic  m_we;
    ent_t  m_out;
    logic [15:0] rf [2][8];
    vec_t  tbl[$];
    logic  p_mv;
    logic  p_av;
    ent_t  p_me;
    ent_t  p_ae;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ent_t ent(input logic b, input logic [2:0] r,
                                 input logic [15:0] d);
        ent_t e;
        e.bank = b;
        e.rnum = r;
        e.data = d;
        return e;
    endfunction

    function automatic ent_t rand_ent();
        return ent(1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom));
    endfunction

    function automatic stim_t idle(input logic [2:0] lq, input logic [2:0] rq,
                                   input logic qb);
        stim_t s;
        s.rst   = 1'b0;
        s.flush = 1'b0;
        s.mv    = 1'b0;
        s.me    = '0;
        s.av    = 1'b0;
        s.ae    = '0;
        s.lq    = lq;
        s.rq    = rq;
        s.qb    = qb;
        return s;
    endfunction

    function automatic vec_t row(
        input logic rs, input logic fl,
        input logic mv, input logic mb, input logic [2:0] mr, input logic [15:0] md,
        input logic av, input logic ab, input logic [2:0] ar, input logic [15:0] ad,
        input logic [2:0] lq, input logic [2:0] rq, input logic qb,
        input logic we, input logic [2:0] wn, input logic [15:0] wd, input logic wb,
        input logic lb, input logic rb, input logic mrdy, input logic ardy,
        input logic emp);
        vec_t v;
        v.s       = idle(lq, rq, qb);
        v.s.rst   = rs;
        v.s.flush = fl;
        v.s.mv    = mv;
        v.s.me    = ent(mb, mr, md);
        v.s.av    = av;
        v.s.ae    = ent(ab, ar, ad);
        v.we      = we;
        v.wnum    = wn;
        v.wdata   = wd;
        v.wbank   = wb;
        v.lb      = lb;
        v.rb      = rb;
        v.mrdy    = mrdy;
        v.ardy    = ardy;
        v.emp     = emp;
        return v;
    endfunction

    function automatic logic model_busy(input logic b, input logic [2:0] r);
        if (r == 3'd0) return 1'b0;
        if (m_we && m_out.bank == b && m_out.rnum == r) return 1'b1;
        foreach (mq[i]) begin
            if (mq[i].bank == b && mq[i].rnum == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic exp_mrdy();
        return !cur.flush && (mq.size() < DEPTH);
    endfunction

    function automatic logic exp_ardy();
        return !cur.flush && ((mq.size() + (cur.mv ? 1 : 0)) < DEPTH);
    endfunction

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        cur                    = s;
        rst                    = s.rst;
        bus.flush              = s.flush;
        bus.mem_valid          = s.mv;
        bus.mem_bank           = s.me.bank;
        bus.mem_reg            = s.me.rnum;
        bus.mem_data           = s.me.data;
        bus.alu_valid          = s.av;
        bus.alu_bank           = s.ae.bank;
        bus.alu_reg            = s.ae.rnum;
        bus.alu_data           = s.ae.data;
        bus.left_register_num  = s.lq;
        bus.right_register_num = s.rq;
        bus.query_bank         = s.qb;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".write_en"},   32'(bus.write_en),           32'(m_we));
        check({tag, ".write_num"},  32'(bus.write_register_num), 32'(m_out.rnum));
        check({tag, ".write_data"}, 32'(bus.write_register_in),  32'(m_out.data));
        check({tag, ".write_bank"}, 32'(bus.write_bank),         32'(m_out.bank));
        check({tag, ".left_busy"},  32'(bus.left_busy),  32'(model_busy(cur.qb, cur.lq)));
        check({tag, ".right_busy"}, 32'(bus.right_busy), 32'(model_busy(cur.qb, cur.rq)));
        check({tag, ".mem_ready"},  32'(bus.mem_ready),  32'(exp_mrdy()));
        check({tag, ".alu_ready"},  32'(bus.alu_ready),  32'(exp_ardy()));
        check({tag, ".empty"},      32'(bus.empty),      32'(mq.size() == 0 && !m_we));
        if (bus.write_en === 1'b1) begin
            rf[bus.write_bank][bus.write_register_num] = bus.write_register_in;
        end
    endtask

    task automatic checkRow(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("row%0d", idx);
        check({tag, ".we"},    32'(bus.write_en),           32'(v.we));
        check({tag, ".wnum"},  32'(bus.write_register_num), 32'(v.wnum));
        check({tag, ".wdata"}, 32'(bus.write_register_in),  32'(v.wdata));
        check({tag, ".wbank"}, 32'(bus.write_bank),         32'(v.wbank));
        check({tag, ".lbusy"}, 32'(bus.left_busy),          32'(v.lb));
        check({tag, ".rbusy"}, 32'(bus.right_busy),         32'(v.rb));
        check({tag, ".mrdy"},  32'(bus.mem_ready),          32'(v.mrdy));
        check({tag, ".ardy"},  32'(bus.alu_ready),          32'(v.ardy));
        check({tag, ".empty"}, 32'(bus.empty),              32'(v.emp));
    endtask

    task automatic advanceModel();
        logic mf;
        logic af;
        mf = cur.mv && exp_mrdy();
        af = cur.av && exp_ardy();
        if (cur.rst || cur.flush) begin
            mq.delete();
            m_we = 1'b0;
            if (cur.rst) m_out = '0;
        end else begin
            if (mq.size() > 0) begin
                m_we  = 1'b1;
                m_out = mq.pop_front();
            end else begin
                m_we = 1'b0;
            end
            if (mf) mq.push_back(cur.me);
            if (af) mq.push_back(cur.ae);
        end
    endtask

    task automatic cycle(input stim_t s, input string tag);
        applyStimulus(s);
        checkOutput(tag);
        advanceModel();
    endtask

    task automatic runTraffic(input int n, input int pct, input int flush_pm,
                              input int rst_pm, input string tag);
        stim_t s;
        logic  macc;
        logic  aacc;
        for (int i = 0; i < n; i++) begin
            if (!p_mv && $urandom_range(99) < pct) begin
                p_mv = 1'b1;
                p_me = rand_ent();
            end
            if (!p_av && $urandom_range(99) < pct) begin
                p_av = 1'b1;
                p_ae = rand_ent();
            end
            s       = idle(3'($urandom_range(7)), 3'($urandom_range(7)),
                           1'($urandom_range(1)));
            s.rst   = ($urandom_range(999) < rst_pm);
            s.flush = ($urandom_range(999) < flush_pm);
            s.mv    = p_mv;
            s.me    = p_me;
            s.av    = p_av;
            s.ae    = p_ae;
            applyStimulus(s);
            checkOutput(tag);
            if (p_mv && p_av && !s.flush && bus.alu_ready === 1'b0) throttled++;
            macc = p_mv && exp_mrdy();
            aacc = p_av && exp_ardy();
            advanceModel();
            if (macc) p_mv = 1'b0;
            if (aacc) p_av = 1'b0;
        end
    endtask

    initial begin
        stim_t s;
        checks    = 0;
        failures  = 0;
        throttled = 0;
        p_mv      = 1'b0;
        p_av      = 1'b0;
        p_me      = '0;
        p_ae      = '0;
        m_we      = 1'b0;
        m_out     = '0;
        cur       = idle(3'd0, 3'd0, 1'b0);
        cur.rst   = 1'b1;
        rst                    = 1'b1;
        bus.flush              = 1'b0;
        bus.mem_valid          = 1'b0;
        bus.mem_bank           = 1'b0;
        bus.mem_reg            = '0;
        bus.mem_data           = '0;
        bus.alu_valid          = 1'b0;
        bus.alu_bank           = 1'b0;
        bus.alu_reg            = '0;
        bus.alu_data           = '0;
        bus.left_register_num  = '0;
        bus.right_register_num = '0;
        bus.query_bank         = 1'b0;

        //            rs fl mv mb mr  md        av ab ar  ad        lq  rq  qb  we wn  wd        wb lb rb mr ar em
        tbl.push_back(row(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 3, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 1, 0, 3, 16'h1234, 3, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 3, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 3, 0, 0, 1, 3, 16'h1234, 0, 1, 0, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 3, 0, 0, 0, 3, 16'h1234, 0, 0, 0, 1, 1, 1));
        tbl.push_back(row(0, 0, 1, 0, 2, 16'hAAAA, 1, 0, 5, 16'h5555, 2, 5, 0, 0, 3, 16'h1234, 0, 0, 0, 1, 1, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 2, 5, 0, 0, 3, 16'h1234, 0, 1, 1, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 2, 5, 0, 1, 2, 16'hAAAA, 0, 1, 1, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 2, 5, 0, 1, 5, 16'h5555, 0, 0, 1, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 2, 5, 0, 0, 5, 16'h5555, 0, 0, 0, 1, 1, 1));
        tbl.push_back(row(0, 0, 1, 0, 4, 16'h0001, 1, 0, 4, 16'h0002, 4, 0, 0, 0, 5, 16'h5555, 0, 0, 0, 1, 1, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 4, 0, 0, 0, 5, 16'h5555, 0, 1, 0, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 4, 0, 0, 1, 4, 16'h0001, 0, 1, 0, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 4, 0, 0, 1, 4, 16'h0002, 0, 1, 0, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 4, 0, 0, 0, 4, 16'h0002, 0, 0, 0, 1, 1, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 4, 16'h0002, 0, 0, 0, 1, 1, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 4, 16'h0002, 0, 0, 0, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 1, 1, 6, 16'h7777, 6, 6, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 6, 6, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 6, 6, 1, 1, 6, 16'h7777, 1, 1, 1, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 6, 6, 1, 0, 6, 16'h7777, 1, 0, 0, 1, 1, 1));

        $display("[TB] directed vectors");
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].s);
            checkOutput($sformatf("vec%0d", i));
            checkRow(tbl[i], i);
            advanceModel();
        end
        check("regfile.r4_final", 32'(rf[0][4]), 32'h0002);

        $display("[TB] fill with both producers saturating");
        runTraffic(10, 100, 0, 0, "fill");
        check("fill.alu_throttled", 32'(throttled > 0), 32'd1);
        runTraffic(10, 0, 0, 0, "drain");

        $display("[TB] flush with three entries queued");
        s    = idle(3'd3, 3'd4, 1'b0);
        s.mv = 1'b1; s.me = ent(1'b0, 3'd1, 16'h0101);
        s.av = 1'b1; s.ae = ent(1'b0, 3'd2, 16'h0202);
        cycle(s, "fl_push0");
        s.me = ent(1'b0, 3'd3, 16'h0303);
        s.ae = ent(1'b0, 3'd4, 16'h0404);
        cycle(s, "fl_push1");
        s.flush = 1'b1;
        s.me = ent(1'b0, 3'd5, 16'h0505);
        s.ae = ent(1'b0, 3'd6, 16'h0606);
        applyStimulus(s);
        checkOutput("fl_cycle");
        check("flush.mem_ready", 32'(bus.mem_ready), 32'd0);
        check("flush.alu_ready", 32'(bus.alu_ready), 32'd0);
        advanceModel();
        applyStimulus(idle(3'd3, 3'd4, 1'b0));
        checkOutput("fl_after");
        check("flush.write_en", 32'(bus.write_en), 32'd0);
        check("flush.empty", 32'(bus.empty), 32'd1);
        check("flush.left_busy", 32'(bus.left_busy), 32'd0);
        check("flush.right_busy", 32'(bus.right_busy), 32'd0);
        advanceModel();

        $display("[TB] randomized traffic");
        runTraffic(600, 60, 25, 12, "rand");
        runTraffic(12, 0, 0, 0, "rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
